// File: rtl/boundary_pkg.sv
// boundary_pkg: shared types and constants for the boundary-box controller.
// Provides the controller state encoding, the default coordinate width and
// the clear values loaded into the min/max trackers at each frame start.
package boundary_pkg;

    // Default width of hcount/vcount and of the committed box edges.
    localparam int BB_CW = 12;

    // Controller states: wait for the first frame edge, scan pixels, publish box.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        COMMIT = 2'd2
    } bb_state_t;

    // Min trackers start at all-ones and max trackers at zero, so the first
    // foreground pixel of a frame always replaces both.
    localparam logic [BB_CW-1:0] BB_MIN_CLR = '1;
    localparam logic [BB_CW-1:0] BB_MAX_CLR = '0;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: polarity-aware rising-edge detector for a sync signal.
// Produces a one-cycle pulse on the first cycle the sync reaches its active
// level. Used for vsync here and for hsync in the line-based stages.
module sync_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic pixelclk,
    input  logic reset,
    input  logic sync_in,
    output logic pulse
);

    logic act;
    logic act_d;

    assign act   = (sync_in == POL);
    assign pulse = act & ~act_d;

    // Register the active-level flag; reset treats sync as inactive.
    always_ff @(posedge pixelclk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            act_d <= 1'b0;
        end else begin
            act_d <= act;
        end
    end

endmodule

// File: rtl/boundary_box_ctrl.sv
// boundary_box_ctrl: per-frame bounding box of foreground mask pixels.
// Tracks min/max column and row of qualified foreground pixels over a frame
// and publishes the box on each vsync edge for the boundary overlay stage.
// Optional macro BOUNDARY_BOX_HOLD_EN: invalid frames keep the previous box
// for up to HOLD_FRAMES commits before it is cleared.
module boundary_box_ctrl
    import boundary_pkg::*;
#(
    parameter int   CW          = BB_CW,
    parameter logic VS_POL      = 1'b1,
    parameter int   MIN_PIXELS  = 64,
    parameter int   CNT_W       = 20,
    parameter int   HOLD_FRAMES = 4
) (
    input  logic          pixelclk,
    input  logic          reset,
    input  logic          i_bin,
    input  logic          i_de,
    input  logic          i_vsync,
    input  logic [CW-1:0] hcount,
    input  logic [CW-1:0] vcount,
    input  logic          i_en,
    output logic [CW-1:0] hcount_l,
    output logic [CW-1:0] hcount_r,
    output logic [CW-1:0] vcount_l,
    output logic [CW-1:0] vcount_r,
    output logic          o_valid,
    output logic          o_frame_done
);

    // Clear values stretched to the configured coordinate width.
    localparam logic [CW-1:0]    MIN_CLR = {CW{BB_MIN_CLR[0]}};
    localparam logic [CW-1:0]    MAX_CLR = {CW{BB_MAX_CLR[0]}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_PX  = CNT_W'(MIN_PIXELS);

    if (MIN_PIXELS < 0 || CNT_W < 1 || HOLD_FRAMES < 1) begin : g_bad_param
        $error("boundary_box_ctrl: illegal parameter value");
    end

    bb_state_t        state;
    logic [CW-1:0]    hmin, hmax, vmin, vmax;
    logic [CNT_W-1:0] cnt;
    logic             vs_edge;
    logic             fg_px;
    logic             box_ok;

    assign fg_px  = i_de & i_bin;
    assign box_ok = (cnt >= MIN_PX);

    sync_edge_det #(
        .POL (VS_POL)
    ) u_vs_edge (
        .pixelclk (pixelclk),
        .reset    (reset),
        .sync_in  (i_vsync),
        .pulse    (vs_edge)
    );

    // Frame sequencing and min/max/count accumulation over one frame.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state <= IDLE;
            hmin  <= MIN_CLR;
            hmax  <= MAX_CLR;
            vmin  <= MIN_CLR;
            vmax  <= MAX_CLR;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // First edge only arms; the partial frame before it is dropped.
                    if (vs_edge) begin
                        hmin  <= MIN_CLR;
                        hmax  <= MAX_CLR;
                        vmin  <= MIN_CLR;
                        vmax  <= MAX_CLR;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    // The pixel in the edge cycle still belongs to the closing frame.
                    if (fg_px) begin
                        if (hcount < hmin) hmin <= hcount;
                        if (hcount > hmax) hmax <= hcount;
                        if (vcount < vmin) vmin <= vcount;
                        if (vcount > vmax) vmax <= vcount;
                        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
                    end
                    if (vs_edge) state <= COMMIT;
                end
                COMMIT: begin
                    hmin  <= MIN_CLR;
                    hmax  <= MAX_CLR;
                    vmin  <= MIN_CLR;
                    vmax  <= MAX_CLR;
                    cnt   <= '0;
                    state <= ACCUM;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BOUNDARY_BOX_HOLD_EN
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_FRAMES);
    logic [HW-1:0] hold_cnt;
`endif

    // Publish the box once per frame; outputs only change in COMMIT.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            hcount_l     <= '0;
            hcount_r     <= '0;
            vcount_l     <= '0;
            vcount_r     <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
`ifdef BOUNDARY_BOX_HOLD_EN
            hold_cnt     <= '0;
`endif
        end else begin
            o_frame_done <= (state == COMMIT);
            if (state == COMMIT && i_en) begin
                if (box_ok) begin
                    hcount_l <= hmin;
                    hcount_r <= hmax;
                    vcount_l <= vmin;
                    vcount_r <= vmax;
                    o_valid  <= 1'b1;
`ifdef BOUNDARY_BOX_HOLD_EN
                    hold_cnt <= '0;
`endif
                end else begin
`ifdef BOUNDARY_BOX_HOLD_EN
                    // Ride out short dropouts; clear once the hold budget is spent.
                    if (hold_cnt >= HOLD_LIM) begin
                        hcount_l <= '0;
                        hcount_r <= '0;
                        vcount_l <= '0;
                        vcount_r <= '0;
                        o_valid  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
`else
                    // An all-zero box draws nothing downstream.
                    hcount_l <= '0;
                    hcount_r <= '0;
                    vcount_l <= '0;
                    vcount_r <= '0;
                    o_valid  <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_boundary_box_ctrl.sv
// tb_boundary_box_ctrl: scoreboard bench for boundary_box_ctrl.
// Two instances share one pixel stream: dut_a needs 50 foreground pixels,
// dut_b needs 1. Expected boxes are queued when the committing vsync edge is
// driven; per-DUT monitors pop and compare on every o_frame_done.
// Expectations follow BOUNDARY_BOX_HOLD_EN when that macro is defined.
module tb_boundary_box_ctrl;

    localparam int CW = 12;

`ifdef BOUNDARY_BOX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct packed {
        logic [CW-1:0] hl;
        logic [CW-1:0] hr;
        logic [CW-1:0] vl;
        logic [CW-1:0] vr;
        logic          v;
    } box_t;

    typedef struct {
        box_t box;
        int   cyc;
    } exp_t;

    localparam box_t Z  = '0;
    localparam box_t R1 = '{12'd10,   12'd20,   12'd5,  12'd9,  1'b1};
    localparam box_t R2 = '{12'd30,   12'd45,   12'd20, 12'd27, 1'b1};
    localparam box_t T  = '{12'd40,   12'd49,   12'd30, 12'd30, 1'b1};
    localparam box_t S  = '{12'd4095, 12'd4095, 12'd0,  12'd0,  1'b1};

    localparam int K_RECT   = 0;
    localparam int K_RECT2  = 1;
    localparam int K_TEN    = 2;
    localparam int K_SINGLE = 3;

    logic          pixelclk = 1'b0;
    logic          reset;
    logic          i_bin, i_de, i_vsync, i_en;
    logic [CW-1:0] hcount, vcount;

    logic [CW-1:0] a_hl, a_hr, a_vl, a_vr, b_hl, b_hr, b_vl, b_vr;
    logic          a_valid, a_done, b_valid, b_done;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    always #5 pixelclk = ~pixelclk;
    always @(posedge pixelclk) cyc <= cyc + 1;

    boundary_box_ctrl #(
        .CW(CW), .VS_POL(1'b1), .MIN_PIXELS(50), .CNT_W(20), .HOLD_FRAMES(2)
    ) dut_a (
        .pixelclk(pixelclk), .reset(reset), .i_bin(i_bin), .i_de(i_de),
        .i_vsync(i_vsync), .hcount(hcount), .vcount(vcount), .i_en(i_en),
        .hcount_l(a_hl), .hcount_r(a_hr), .vcount_l(a_vl), .vcount_r(a_vr),
        .o_valid(a_valid), .o_frame_done(a_done)
    );

    boundary_box_ctrl #(
        .CW(CW), .VS_POL(1'b1), .MIN_PIXELS(1), .CNT_W(20), .HOLD_FRAMES(2)
    ) dut_b (
        .pixelclk(pixelclk), .reset(reset), .i_bin(i_bin), .i_de(i_de),
        .i_vsync(i_vsync), .hcount(hcount), .vcount(vcount), .i_en(i_en),
        .hcount_l(b_hl), .hcount_r(b_hr), .vcount_l(b_vl), .vcount_r(b_vr),
        .o_valid(b_valid), .o_frame_done(b_done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic box_t cur_a();
        return '{a_hl, a_hr, a_vl, a_vr, a_valid};
    endfunction

    function automatic box_t cur_b();
        return '{b_hl, b_hr, b_vl, b_vr, b_valid};
    endfunction

    function automatic logic fg(input int kind, input int x, input int y);
        case (kind)
            K_RECT:  return (x >= 10 && x <= 20 && y >= 5 && y <= 9);
            K_RECT2: return (x >= 30 && x <= 45 && y >= 20 && y <= 27);
            K_TEN:   return (y == 30 && x >= 40 && x <= 49);
            default: return 1'b0;
        endcase
    endfunction

    // Monitor for dut_a: every frame-done pulse must match the next queued box.
    always @(negedge pixelclk) begin
        if (a_done === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_spurious_done", 64'(a_done), 64'd0);
            end else begin
                ea = q_a.pop_front();
                check("a_box", 64'(cur_a()), 64'(ea.box));
                check("a_done_cycle", 64'(cyc), 64'(ea.cyc));
            end
        end
    end

    // Monitor for dut_b.
    always @(negedge pixelclk) begin
        if (b_done === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_spurious_done", 64'(b_done), 64'd0);
            end else begin
                eb = q_b.pop_front();
                check("b_box", 64'(cur_b()), 64'(eb.box));
                check("b_done_cycle", 64'(cyc), 64'(eb.cyc));
            end
        end
    end

    // Vsync pulse of len cycles; when commit is set, queue the boxes expected
    // two cycles after the edge cycle. i_en is held for the whole pulse.
    task automatic drive_edge(input int len, input logic en, input logic commit,
                              input box_t xa, input box_t xb);
        exp_t e;
        @(negedge pixelclk);
        i_vsync = 1'b1; i_de = 1'b0; i_bin = 1'b1; hcount = '0; vcount = '0; i_en = en;
        if (commit) begin
            e.cyc = cyc + 2;
            e.box = xa; q_a.push_back(e);
            e.box = xb; q_b.push_back(e);
        end
        repeat (len - 1) @(negedge pixelclk);
        @(negedge pixelclk);
        i_vsync = 1'b0; i_en = 1'b1; i_bin = 1'b0;
    endtask

    // One 64x48 raster; reset_at >= 0 pulses reset at that pixel index and
    // checks that both DUTs show a cleared box on the following cycle.
    task automatic drive_frame(input int kind, input int reset_at);
        int idx = 0;
        for (int y = 0; y < 48; y++) begin
            for (int x = 0; x < 64; x++) begin
                @(negedge pixelclk);
                if (reset_at >= 0 && idx == reset_at + 1) begin
                    check("a_midframe_reset", 64'({cur_a(), a_done}), 64'd0);
                    check("b_midframe_reset", 64'({cur_b(), b_done}), 64'd0);
                end
                reset  = (idx == reset_at);
                i_de   = 1'b1;
                hcount = CW'(x);
                vcount = CW'(y);
                i_bin  = fg(kind, x, y);
                idx++;
            end
        end
        if (kind == K_SINGLE) begin
            @(negedge pixelclk);
            i_de = 1'b1; i_bin = 1'b1; hcount = 12'd4095; vcount = 12'd0;
        end
        // Blanking pixel with mask set: must be ignored because i_de is low.
        @(negedge pixelclk);
        reset = 1'b0; i_de = 1'b0; i_bin = 1'b1; hcount = 12'd1; vcount = 12'd1;
        repeat (3) begin
            @(negedge pixelclk);
            i_bin = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; i_bin = 1'b0; i_de = 1'b0; i_vsync = 1'b0; i_en = 1'b1;
        hcount = '0; vcount = '0;
        repeat (3) @(negedge pixelclk);
        check("a_reset_box",  64'(cur_a()), 64'(Z));
        check("a_reset_done", 64'(a_done), 64'd0);
        check("b_reset_box",  64'(cur_b()), 64'(Z));
        check("b_reset_done", 64'(b_done), 64'd0);
        reset = 1'b0;

        // Arming edge: no commit.
        drive_edge(4, 1'b1, 1'b0, Z, Z);

        // Three identical valid frames.
        for (int i = 0; i < 3; i++) begin
            drive_frame(K_RECT, -1);
            drive_edge(4, 1'b1, 1'b1, R1, R1);
        end

        // Three sparse frames: invalid for dut_a, valid for dut_b.
        for (int i = 0; i < 3; i++) begin
            drive_frame(K_TEN, -1);
            drive_edge(4, 1'b1, 1'b1, (HOLD && i < 2) ? R1 : Z, T);
        end

        // Valid frame restores the box.
        drive_frame(K_RECT2, -1);
        drive_edge(4, 1'b1, 1'b1, R2, R2);

        // Commit disabled: previous box kept, done still pulses.
        drive_frame(K_RECT, -1);
        drive_edge(4, 1'b0, 1'b1, R2, R2);

        // Commit re-enabled: new box.
        drive_frame(K_RECT, -1);
        drive_edge(4, 1'b1, 1'b1, R1, R1);

        // One invalid frame after a valid commit.
        drive_frame(K_TEN, -1);
        drive_edge(4, 1'b1, 1'b1, HOLD ? R1 : Z, T);

        // Reset mid-frame, then the first edge only re-arms.
        drive_frame(K_RECT, 1000);
        drive_edge(4, 1'b1, 1'b0, Z, Z);
        drive_frame(K_RECT, -1);
        drive_edge(4, 1'b1, 1'b1, R1, R1);

        // Single corner pixel, vsync held for 100 cycles.
        drive_frame(K_SINGLE, -1);
        drive_edge(100, 1'b1, 1'b1, HOLD ? R1 : Z, S);

        repeat (20) @(negedge pixelclk);
        check("a_pending_commits", 64'(q_a.size()), 64'd0);
        check("b_pending_commits", 64'(q_b.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
